rob_retire_unit: RTL and testbench



---
 rtl/rob_retire_unit.sv | 132 +++++++++++++
 tb/tb_rob_retire_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire_unit.sv
// Two-wide in-order retire stage: ROB commit -> retire FIFO -> 32x16 register file / store port.
// Optional retired-entry counter output enabled by defining RETIRE_COUNTER_EN.
module rob_retire_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef RETIRE_COUNTER_EN
  output logic [31:0] retCount,
`endif
  input  logic        cmtValid1,
  input  logic        cmtValid2,
  input  logic [3:0]  cmtTag1,
  input  logic [3:0]  cmtTag2,
  input  logic [4:0]  cmtDest1,
  input  logic [4:0]  cmtDest2,
  input  logic [1:0]  cmtType1,
  input  logic [1:0]  cmtType2,
  input  logic [15:0] cmtData1,
  input  logic [15:0] cmtData2,
  output logic        stall,
  input  logic [4:0]  rdAddr1,
  input  logic [4:0]  rdAddr2,
  output logic [15:0] rdData1,
  output logic [15:0] rdData2,
  output logic        stValid,
  output logic [4:0]  stAddr,
  output logic [15:0] stData,
  input  logic        stReady,
  output logic [3:0]  retTag1,
  output logic [3:0]  retTag2,
  output logic        retValid1,
  output logic        retValid2
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_TWO   = (PW+1)'(2);
  localparam logic [PW:0] STALL_LIM = (PW+1)'(DEPTH - 2);

  typedef enum logic [1:0] {
    TY_ALU    = 2'b00,
    TY_LOAD   = 2'b01,
    TY_STORE  = 2'b10,
    TY_BRANCH = 2'b11
  } ent_type_e;

  logic [3:0]    tag_q  [DEPTH];
  logic [4:0]    dest_q [DEPTH];
  logic [1:0]    type_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   regs   [32];

  logic [PW-1:0] head, tail, head_b, tail_b;
  logic [PW:0]   count, next_count, enq_cnt, ret_cnt;
  logic          en1, en2, a_avail, a_store, ret_a, ret_b, wr_a, wr_b, stall_next;

  // Retire decision for the two oldest entries; a store may only leave from the head.
  always_comb begin
    head_b     = head + 1'b1;
    tail_b     = en1 ? tail + 1'b1 : tail;
    en1        = !stall && cmtValid1;
    en2        = !stall && cmtValid2;
    a_avail    = count != '0;
    a_store    = type_q[head] == TY_STORE;
    ret_a      = a_avail && (!a_store || stReady);
    ret_b      = ret_a && (count >= CNT_TWO) && (type_q[head_b] != TY_STORE);
    wr_a       = ret_a && (type_q[head] == TY_ALU || type_q[head] == TY_LOAD) && (dest_q[head] != 5'd0);
    wr_b       = ret_b && (type_q[head_b] == TY_ALU || type_q[head_b] == TY_LOAD) && (dest_q[head_b] != 5'd0);
    enq_cnt    = {{PW{1'b0}}, en1} + {{PW{1'b0}}, en2};
    ret_cnt    = {{PW{1'b0}}, ret_a} + {{PW{1'b0}}, ret_b};
    next_count = count + enq_cnt - ret_cnt;
    stall_next = next_count > STALL_LIM;
  end

  assign stValid = a_avail && a_store;
  assign stAddr  = dest_q[head];
  assign stData  = data_q[head];
  assign rdData1 = regs[rdAddr1];
  assign rdData2 = regs[rdAddr2];

  // FIFO payload needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (en1) begin
        tag_q[tail]  <= cmtTag1;
        dest_q[tail] <= cmtDest1;
        type_q[tail] <= cmtType1;
        data_q[tail] <= cmtData1;
      end
      if (en2) begin
        tag_q[tail_b]  <= cmtTag2;
        dest_q[tail_b] <= cmtDest2;
        type_q[tail_b] <= cmtType2;
        data_q[tail_b] <= cmtData2;
      end
    end
  end

  // Slot B's register write is issued last so it wins on a shared destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall     <= 1'b0;
      retValid1 <= 1'b0;
      retValid2 <= 1'b0;
      retTag1   <= '0;
      retTag2   <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      tail      <= tail + enq_cnt[PW-1:0];
      head      <= head + ret_cnt[PW-1:0];
      count     <= next_count;
      stall     <= stall_next;
      retValid1 <= ret_a;
      retValid2 <= ret_b;
      retTag1   <= ret_a ? tag_q[head] : 4'd0;
      retTag2   <= ret_b ? tag_q[head_b] : 4'd0;
      if (wr_a) regs[dest_q[head]] <= data_q[head];
      if (wr_b) regs[dest_q[head_b]] <= data_q[head_b];
    end
  end

`ifdef RETIRE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) retCount <= '0;
    else     retCount <= retCount + 32'(ret_cnt);
  end
`endif

endmodule

// File: tb/tb_rob_retire_unit.sv
// Self-checking bench for rob_retire_unit: directed vector table, corner sequences, random vs queue model.
module tb_rob_retire_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmtValid1, cmtValid2;
  logic [3:0]  cmtTag1, cmtTag2;
  logic [4:0]  cmtDest1, cmtDest2;
  logic [1:0]  cmtType1, cmtType2;
  logic [15:0] cmtData1, cmtData2;
  logic        stall;
  logic [4:0]  rdAddr1, rdAddr2;
  logic [15:0] rdData1, rdData2;
  logic        stValid;
  logic [4:0]  stAddr;
  logic [15:0] stData;
  logic        stReady;
  logic [3:0]  retTag1, retTag2;
  logic        retValid1, retValid2;
`ifdef RETIRE_COUNTER_EN
  logic [31:0] retCount;
`endif

  int tests = 0;
  int fails = 0;

  rob_retire_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
`ifdef RETIRE_COUNTER_EN
    .retCount(retCount),
`endif
    .cmtValid1(cmtValid1), .cmtValid2(cmtValid2), .cmtTag1(cmtTag1), .cmtTag2(cmtTag2),
    .cmtDest1(cmtDest1), .cmtDest2(cmtDest2), .cmtType1(cmtType1), .cmtType2(cmtType2),
    .cmtData1(cmtData1), .cmtData2(cmtData2), .stall(stall),
    .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1), .rdData2(rdData2),
    .stValid(stValid), .stAddr(stAddr), .stData(stData), .stReady(stReady),
    .retTag1(retTag1), .retTag2(retTag2), .retValid1(retValid1), .retValid2(retValid2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v1; logic [1:0] ty1; logic [4:0] d1; logic [15:0] dat1; logic [3:0] tg1;
    logic v2; logic [1:0] ty2; logic [4:0] d2; logic [15:0] dat2; logic [3:0] tg2;
    logic rdy; logic [4:0] ra;
    logic e_rv1; logic [3:0] e_rt1; logic e_rv2; logic [3:0] e_rt2;
    logic e_stall; logic e_stv; logic [4:0] e_sta; logic [15:0] e_std; logic [15:0] e_rd;
  } vec_t;

  typedef struct packed {
    logic [3:0] tag; logic [4:0] dest; logic [1:0] typ; logic [15:0] data;
  } ent_t;

  vec_t        vecs [14];
  ent_t        mq [$];
  logic [15:0] mregs [32];
  logic        m_stall, m_rv1, m_rv2;
  logic [3:0]  m_rt1, m_rt2;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    cmtValid1 = 1'b0; cmtTag1 = '0; cmtDest1 = '0; cmtType1 = '0; cmtData1 = '0;
    cmtValid2 = 1'b0; cmtTag2 = '0; cmtDest2 = '0; cmtType2 = '0; cmtData2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    cmtValid1 = v.v1; cmtType1 = v.ty1; cmtDest1 = v.d1; cmtData1 = v.dat1; cmtTag1 = v.tg1;
    cmtValid2 = v.v2; cmtType2 = v.ty2; cmtDest2 = v.d2; cmtData2 = v.dat2; cmtTag2 = v.tg2;
    stReady = v.rdy; rdAddr1 = v.ra; rdAddr2 = 5'd0;
  endtask

  task automatic doReset();
    rst = 1'b1; clearInputs(); stReady = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic void modelReset();
    mq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_stall = 1'b0; m_rv1 = 1'b0; m_rv2 = 1'b0; m_rt1 = '0; m_rt2 = '0;
  endfunction

  function automatic void modelWrite(input ent_t e);
    if ((e.typ == 2'b00 || e.typ == 2'b01) && e.dest != 5'd0) mregs[e.dest] = e.data;
  endfunction

  // Advance the reference one clock using the inputs currently being driven.
  function automatic void modelStep();
    ent_t e;
    logic ra, rb;
    if (rst) begin
      modelReset();
      return;
    end
    ra = (mq.size() > 0) && (mq[0].typ != 2'b10 || stReady);
    rb = ra && (mq.size() >= 2) && (mq[1].typ != 2'b10);
    m_rv1 = ra; m_rv2 = rb;
    if (ra) begin e = mq.pop_front(); m_rt1 = e.tag; modelWrite(e); end
    if (rb) begin e = mq.pop_front(); m_rt2 = e.tag; modelWrite(e); end
    if (!m_stall) begin
      if (cmtValid1) mq.push_back('{cmtTag1, cmtDest1, cmtType1, cmtData1});
      if (cmtValid2) mq.push_back('{cmtTag2, cmtDest2, cmtType2, cmtData2});
    end
    m_stall = mq.size() > DEPTH - 2;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] exp_tags [$];
    logic [3:0] next_tag;
    logic [3:0] want;
    int sent, got, cyc;

    // v1 ty1 d1 dat1 tg1 | v2 ty2 d2 dat2 tg2 | rdy ra | rv1 rt1 rv2 rt2 | stall stv sta std rd
    vecs[0]  = '{1'b1,2'd0,5'd5,16'h1234,4'h1, 1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd5, 1'b0,4'h0,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h0000};
    vecs[1]  = '{1'b0,2'd0,5'd0,16'h0,4'h0,    1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd5, 1'b1,4'h1,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h1234};
    vecs[2]  = '{1'b1,2'd0,5'd3,16'h0001,4'h2, 1'b1,2'd1,5'd3,16'h0002,4'h3, 1'b0,5'd3, 1'b0,4'h0,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h0000};
    vecs[3]  = '{1'b0,2'd0,5'd0,16'h0,4'h0,    1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd3, 1'b1,4'h2,1'b1,4'h3, 1'b0,1'b0,5'd0,16'h0,16'h0002};
    vecs[4]  = '{1'b1,2'd0,5'd0,16'hFFFF,4'h4, 1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd0, 1'b0,4'h0,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h0000};
    vecs[5]  = '{1'b0,2'd0,5'd0,16'h0,4'h0,    1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd0, 1'b1,4'h4,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h0000};
    vecs[6]  = '{1'b1,2'd2,5'd7,16'hBEEF,4'h5, 1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd0, 1'b0,4'h0,1'b0,4'h0, 1'b0,1'b1,5'd7,16'hBEEF,16'h0000};
    vecs[7]  = '{1'b1,2'd0,5'd1,16'h0011,4'h6, 1'b1,2'd0,5'd2,16'h0022,4'h7, 1'b0,5'd1, 1'b0,4'h0,1'b0,4'h0, 1'b1,1'b1,5'd7,16'hBEEF,16'h0000};
    vecs[8]  = '{1'b1,2'd0,5'd9,16'h0099,4'h8, 1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd1, 1'b0,4'h0,1'b0,4'h0, 1'b1,1'b1,5'd7,16'hBEEF,16'h0000};
    vecs[9]  = '{1'b0,2'd0,5'd0,16'h0,4'h0,    1'b0,2'd0,5'd0,16'h0,4'h0, 1'b1,5'd1, 1'b1,4'h5,1'b1,4'h6, 1'b0,1'b0,5'd0,16'h0,16'h0011};
    vecs[10] = '{1'b0,2'd0,5'd0,16'h0,4'h0,    1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd2, 1'b1,4'h7,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h0022};
    vecs[11] = '{1'b0,2'd0,5'd0,16'h0,4'h0,    1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd9, 1'b0,4'h0,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h0000};
    vecs[12] = '{1'b1,2'd3,5'd6,16'h6666,4'h9, 1'b1,2'd0,5'd6,16'h0066,4'hA, 1'b0,5'd6, 1'b0,4'h0,1'b0,4'h0, 1'b0,1'b0,5'd0,16'h0,16'h0000};
    vecs[13] = '{1'b0,2'd0,5'd0,16'h0,4'h0,    1'b0,2'd0,5'd0,16'h0,4'h0, 1'b0,5'd6, 1'b1,4'h9,1'b1,4'hA, 1'b0,1'b0,5'd0,16'h0,16'h0066};

    rst = 1'b1; clearInputs(); stReady = 1'b0; rdAddr1 = 5'd5; rdAddr2 = 5'd0;
    tick(); tick();
    checkOutput("reset_rd_r5", 32'(rdData1), 32'h0);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_stValid", 32'(stValid), 32'h0);
    checkOutput("reset_retValid1", 32'(retValid1), 32'h0);
    checkOutput("reset_retValid2", 32'(retValid2), 32'h0);
`ifdef RETIRE_COUNTER_EN
    checkOutput("reset_retCount", retCount, 32'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d_retValid1", i), 32'(retValid1), 32'(vecs[i].e_rv1));
      checkOutput($sformatf("v%0d_retValid2", i), 32'(retValid2), 32'(vecs[i].e_rv2));
      if (vecs[i].e_rv1) checkOutput($sformatf("v%0d_retTag1", i), 32'(retTag1), 32'(vecs[i].e_rt1));
      if (vecs[i].e_rv2) checkOutput($sformatf("v%0d_retTag2", i), 32'(retTag2), 32'(vecs[i].e_rt2));
      checkOutput($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      checkOutput($sformatf("v%0d_stValid", i), 32'(stValid), 32'(vecs[i].e_stv));
      if (vecs[i].e_stv) begin
        checkOutput($sformatf("v%0d_stAddr", i), 32'(stAddr), 32'(vecs[i].e_sta));
        checkOutput($sformatf("v%0d_stData", i), 32'(stData), 32'(vecs[i].e_std));
      end
      checkOutput($sformatf("v%0d_rdData1", i), 32'(rdData1), 32'(vecs[i].e_rd));
    end

    // Back-to-back ALU pairs across several pointer wraps must retire two per cycle in order.
    doReset();
    stReady = 1'b1; sent = 0; got = 0; cyc = 0; next_tag = 4'h0;
    while (got < 40 && cyc < 200) begin
      clearInputs();
      if (!stall && sent < 40) begin
        cmtValid1 = 1'b1; cmtType1 = 2'd0; cmtDest1 = 5'((sent % 31) + 1); cmtData1 = 16'(sent); cmtTag1 = next_tag;
        exp_tags.push_back(next_tag); next_tag = next_tag + 4'd1;
        cmtValid2 = 1'b1; cmtType2 = 2'd0; cmtDest2 = 5'(((sent + 1) % 31) + 1); cmtData2 = 16'(sent + 1); cmtTag2 = next_tag;
        exp_tags.push_back(next_tag); next_tag = next_tag + 4'd1;
        sent += 2;
      end
      tick();
      cyc++;
      if (retValid1) begin
        want = (exp_tags.size() > 0) ? exp_tags.pop_front() : 4'hF;
        checkOutput($sformatf("stream_tag1_%0d", got), 32'(retTag1), 32'(want));
        got++;
      end
      if (retValid2) begin
        want = (exp_tags.size() > 0) ? exp_tags.pop_front() : 4'hF;
        checkOutput($sformatf("stream_tag2_%0d", got), 32'(retTag2), 32'(want));
        got++;
      end
    end
    clearInputs();
    checkOutput("stream_retired", 32'(got), 32'd40);
    checkOutput("stream_cycles", 32'(cyc), 32'd21);
`ifdef RETIRE_COUNTER_EN
    checkOutput("stream_retCount", retCount, 32'd40);
`endif

    // A pending store handshake and the ALU behind it are discarded by reset.
    doReset();
    stReady = 1'b0;
    cmtValid1 = 1'b1; cmtType1 = 2'd2; cmtDest1 = 5'd7; cmtData1 = 16'hBEEF; cmtTag1 = 4'h1;
    cmtValid2 = 1'b1; cmtType2 = 2'd0; cmtDest2 = 5'd4; cmtData2 = 16'h4444; cmtTag2 = 4'h2;
    tick();
    clearInputs();
    checkOutput("midrst_stValid_before", 32'(stValid), 32'h1);
    stReady = 1'b1; rst = 1'b1;
    tick();
    checkOutput("midrst_retValid1", 32'(retValid1), 32'h0);
    checkOutput("midrst_stValid", 32'(stValid), 32'h0);
    checkOutput("midrst_stall", 32'(stall), 32'h0);
    rst = 1'b0; rdAddr1 = 5'd4;
    tick();
    checkOutput("midrst_after_retValid1", 32'(retValid1), 32'h0);
    checkOutput("midrst_after_retValid2", 32'(retValid2), 32'h0);
    checkOutput("midrst_after_stValid", 32'(stValid), 32'h0);
    checkOutput("midrst_after_r4", 32'(rdData1), 32'h0);
`ifdef RETIRE_COUNTER_EN
    checkOutput("midrst_retCount", retCount, 32'h0);
`endif

    // Random traffic, including occasional resets, against the queue model.
    doReset();
    modelReset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      cmtValid1 = 1'($urandom_range(0, 1));
      cmtValid2 = 1'($urandom_range(0, 1));
      cmtType1  = 2'($urandom_range(0, 3));
      cmtType2  = 2'($urandom_range(0, 3));
      cmtDest1  = 5'($urandom_range(0, 31));
      cmtDest2  = 5'($urandom_range(0, 31));
      cmtData1  = 16'($urandom);
      cmtData2  = 16'($urandom);
      cmtTag1   = 4'($urandom);
      cmtTag2   = 4'($urandom);
      stReady   = ($urandom_range(0, 2) != 0);
      rdAddr1   = 5'($urandom_range(0, 31));
      rdAddr2   = 5'($urandom_range(0, 31));
      modelStep();
      tick();
      checkOutput($sformatf("rnd%0d_stall", c), 32'(stall), 32'(m_stall));
      checkOutput($sformatf("rnd%0d_retValid1", c), 32'(retValid1), 32'(m_rv1));
      checkOutput($sformatf("rnd%0d_retValid2", c), 32'(retValid2), 32'(m_rv2));
      if (m_rv1) checkOutput($sformatf("rnd%0d_retTag1", c), 32'(retTag1), 32'(m_rt1));
      if (m_rv2) checkOutput($sformatf("rnd%0d_retTag2", c), 32'(retTag2), 32'(m_rt2));
      checkOutput($sformatf("rnd%0d_stValid", c), 32'(stValid), 32'((mq.size() > 0) && (mq[0].typ == 2'b10)));
      if ((mq.size() > 0) && (mq[0].typ == 2'b10)) begin
        checkOutput($sformatf("rnd%0d_stAddr", c), 32'(stAddr), 32'(mq[0].dest));
        checkOutput($sformatf("rnd%0d_stData", c), 32'(stData), 32'(mq[0].data));
      end
      checkOutput($sformatf("rnd%0d_rdData1", c), 32'(rdData1), 32'(mregs[rdAddr1]));
      checkOutput($sformatf("rnd%0d_rdData2", c), 32'(rdData2), 32'(mregs[rdAddr2]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
